vme_reg_bank_param: RTL and testbench
=====================================

// Module: vme_reg_bank_param
// PURPOSE
// - Parametrised VME-side register bank: N_CTRL read/write control registers plus N_STAT sticky status registers.
// - Status bits are set by hardware pulses and cleared by the host with write-1-to-clear (W1C).
// - Successor of the fixed two-register bank; adds configurable width/depth, an optional write pipeline stage,
//   per-register write pulses and error acks for unmapped addresses.
// - Sits between the VME slave decoder (single-cycle RdMem/WrMem strobes) and the user logic.
// PARAMETERS
// - N_CTRL    4       number of RW control registers (1..16), word addresses 0..N_CTRL-1
// - N_STAT    2       number of W1C status registers (0..16), word addresses N_CTRL..N_CTRL+N_STAT-1
// - REG_W     32      implemented bits per register (1..32); bits [31:REG_W] read as 0, ignored on write
// - ADDR_W    3       word-address bits; must satisfy 2**ADDR_W >= N_CTRL+N_STAT
// - PIPE_WR   1       1: register the write address/data/strobe (input stage); 0: decode the write combinationally
// - CTRL_RST  0       N_CTRL*REG_W-bit reset vector; register i resets to CTRL_RST[i*REG_W +: REG_W]
// PORTS
// - Clk            in   1               system clock, all logic on rising edge
// - rst_n          in   1               asynchronous, active-low reset
// - VMEAddr        in   [ADDR_W+1:2]    word address, shared by reads and writes
// - VMEWrData      in   32              write data
// - VMERdMem       in   1               read strobe, one access per high cycle
// - VMEWrMem       in   1               write strobe, one access per high cycle
// - VMERdData      out  32              read data, valid while VMERdDone=1
// - VMERdDone      out  1               read acknowledge, 1-cycle pulse
// - VMEWrDone      out  1               write acknowledge, 1-cycle pulse
// - VMERdErr       out  1               coincides with VMERdDone when the address is unmapped
// - VMEWrErr       out  1               coincides with VMEWrDone when the address is unmapped
// - ctrl_o         out  N_CTRL*REG_W    control register contents, concatenated (reg 0 in the LSBs)
// - ctrl_wr_o      out  N_CTRL          1-cycle pulse when the matching control register is written
// - stat_set_i     in   N_STAT*REG_W    per-bit set pulses for the status registers
// BEHAVIOUR
// - Reset:
//   - control registers load CTRL_RST; status registers load 0.
//   - VMERdDone, VMEWrDone, VMERdErr, VMEWrErr, ctrl_wr_o and VMERdData are all 0.
//   - Any in-flight access is dropped; no Done is issued for it after reset is released.
// - Write, PIPE_WR=1:
//   - Edge k samples VMEWrMem=1 with the address and data.
//   - Edge k+1 updates the register and raises VMEWrDone and ctrl_wr_o[i], which stay high for one cycle.
// - Write, PIPE_WR=0: the update, VMEWrDone and ctrl_wr_o[i] all happen at edge k (one cycle earlier).
// - Control register write: reg <= VMEWrData[REG_W-1:0].
// - Status register write: reg <= (reg & ~VMEWrData[REG_W-1:0]) | set_bits.
//   - A hardware set wins over a host clear in the same cycle; the bit stays 1.
// - Status set: each cycle, reg |= stat_set_i slice. Bits are sticky until cleared by W1C.
// - Read:
//   - Edge k samples VMERdMem=1.
//   - In the following cycle VMERdDone=1 and VMERdData = {zeros, reg} of the register as it was before edge k.
//   - A read and a write to the same register in the same cycle return the old value.
// - Unmapped address (>= N_CTRL+N_STAT):
//   - Reads: Done=1, Err=1, data 0.
//   - Writes: Done=1, Err=1, no state change, no ctrl_wr_o pulse.
// - Simultaneous RdMem and WrMem: both are serviced independently, each with its own Done at its own latency.
// - Back-to-back strobes on consecutive cycles give back-to-back Done pulses; no access is lost or merged.
// - VMERdData outside a Done cycle is 0.
// TESTING
// - Reset: release rst_n with CTRL_RST=0x...A5 -> ctrl_o reg0=0xA5, all status 0, all Done/Err 0.
// - Write/read: write 0xDEADBEEF to addr 1 (PIPE_WR=1).
//   -> WrDone and ctrl_wr_o[1] pulse 2 edges after the strobe; a later read returns 0xDEADBEEF with RdDone 1 edge after.
// - W1C vs set: stat_set_i bit0 pulse -> reads 0x1.
//   -> Then a W1C of 0x1 in the same cycle as a new bit0 set -> bit0 still 1; a W1C alone -> 0.
// - Unmapped: N_CTRL=4, N_STAT=2, access addr 7 -> RdDone+RdErr with data 0; WrDone+WrErr with no ctrl change.
// - Stream: 4 consecutive write strobes then 4 consecutive reads -> exactly 4 WrDone and 4 RdDone pulses, data correct.
// - Reset mid-op: assert rst_n=0 the cycle after a write strobe -> no WrDone; the register holds its reset value.

Source files
------------

// File: rtl/vme_reg_bank_param.sv
// VME-side register bank: N_CTRL read/write control registers and N_STAT
// sticky write-1-to-clear status registers, with optional registered write stage.
module vme_reg_bank_param #(
  parameter int                        N_CTRL   = 4,
  parameter int                        N_STAT   = 2,
  parameter int                        REG_W    = 32,
  parameter int                        ADDR_W   = 3,
  parameter bit                        PIPE_WR  = 1'b1,
  parameter logic [N_CTRL*REG_W-1:0]   CTRL_RST = '0
) (
  input  logic                                     Clk,
  input  logic                                     rst_n,
  input  logic [ADDR_W+1:2]                        VMEAddr,
  input  logic [31:0]                              VMEWrData,
  input  logic                                     VMERdMem,
  input  logic                                     VMEWrMem,
  output logic [31:0]                              VMERdData,
  output logic                                     VMERdDone,
  output logic                                     VMEWrDone,
  output logic                                     VMERdErr,
  output logic                                     VMEWrErr,
  output logic [N_CTRL*REG_W-1:0]                  ctrl_o,
  output logic [N_CTRL-1:0]                        ctrl_wr_o,
  input  logic [((N_STAT > 0) ? N_STAT : 1)*REG_W-1:0] stat_set_i
);

  localparam int              NS    = (N_STAT > 0) ? N_STAT : 1;
  localparam logic [ADDR_W:0] N_MAP = (ADDR_W+1)'(N_CTRL + N_STAT);

  function automatic logic [31:0] zext(input logic [REG_W-1:0] v);
    logic [31:0] r;
    r          = '0;
    r[REG_W-1:0] = v;
    return r;
  endfunction

  function automatic logic is_mapped(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < N_MAP);
  endfunction

  logic                unused_bits;
  assign unused_bits = ^{VMEWrData, stat_set_i};

  logic                wr_vld_c;
  logic [ADDR_W-1:0]   wr_addr_c;
  logic [REG_W-1:0]    wr_data_c;

  // Stage p0: optional write input register
  generate
    if (PIPE_WR) begin : g_pipe
      logic              wr_vld_p0;
      logic [ADDR_W-1:0] wr_addr_p0;
      logic [REG_W-1:0]  wr_data_p0;

      always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) wr_vld_p0 <= 1'b0;
        else        wr_vld_p0 <= VMEWrMem;
      end

      always_ff @(posedge Clk) begin
        wr_addr_p0 <= VMEAddr;
        wr_data_p0 <= VMEWrData[REG_W-1:0];
      end

      assign wr_vld_c  = wr_vld_p0;
      assign wr_addr_c = wr_addr_p0;
      assign wr_data_c = wr_data_p0;
    end else begin : g_comb
      assign wr_vld_c  = VMEWrMem;
      assign wr_addr_c = VMEAddr;
      assign wr_data_c = VMEWrData[REG_W-1:0];
    end
  endgenerate

  logic [REG_W-1:0] ctrl_q   [N_CTRL];
  logic [REG_W-1:0] stat_q   [NS];
  logic [REG_W-1:0] stat_clr [NS];
  logic [31:0]      rd_mux;

  always_comb begin
    for (int j = 0; j < NS; j++) stat_clr[j] = '0;
    for (int j = 0; j < N_STAT; j++)
      if (wr_vld_c && wr_addr_c == ADDR_W'(N_CTRL + j)) stat_clr[j] = wr_data_c;
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_CTRL; i++)
      if (VMEAddr == ADDR_W'(i)) rd_mux = zext(ctrl_q[i]);
    for (int j = 0; j < N_STAT; j++)
      if (VMEAddr == ADDR_W'(N_CTRL + j)) rd_mux = zext(stat_q[j]);
  end

  // Stage p1: register update and acknowledges
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CTRL; i++) ctrl_q[i] <= CTRL_RST[i*REG_W +: REG_W];
    end else begin
      for (int i = 0; i < N_CTRL; i++)
        if (wr_vld_c && wr_addr_c == ADDR_W'(i)) ctrl_q[i] <= wr_data_c;
    end
  end

  // Hardware set is OR-ed after the clear so a coincident set wins
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NS; j++) stat_q[j] <= '0;
    end else begin
      for (int j = 0; j < N_STAT; j++)
        stat_q[j] <= (stat_q[j] & ~stat_clr[j]) | stat_set_i[j*REG_W +: REG_W];
    end
  end

  logic              wr_vld_p1, wr_err_p1, rd_vld_p1, rd_err_p1;
  logic [N_CTRL-1:0] ctrl_wr_p1;
  logic [31:0]       rd_data_p1;

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_vld_p1  <= 1'b0;
      wr_err_p1  <= 1'b0;
      ctrl_wr_p1 <= '0;
      rd_vld_p1  <= 1'b0;
      rd_err_p1  <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      wr_vld_p1 <= wr_vld_c;
      wr_err_p1 <= wr_vld_c && !is_mapped(wr_addr_c);
      for (int i = 0; i < N_CTRL; i++)
        ctrl_wr_p1[i] <= wr_vld_c && (wr_addr_c == ADDR_W'(i));
      rd_vld_p1  <= VMERdMem;
      rd_err_p1  <= VMERdMem && !is_mapped(VMEAddr);
      rd_data_p1 <= VMERdMem ? rd_mux : '0;
    end
  end

  generate
    for (genvar gi = 0; gi < N_CTRL; gi++) begin : g_ctrl_o
      assign ctrl_o[gi*REG_W +: REG_W] = ctrl_q[gi];
    end
  endgenerate

  assign VMEWrDone = wr_vld_p1;
  assign VMEWrErr  = wr_err_p1;
  assign ctrl_wr_o = ctrl_wr_p1;
  assign VMERdDone = rd_vld_p1;
  assign VMERdErr  = rd_err_p1;
  assign VMERdData = rd_data_p1;

endmodule

// File: tb/tb_vme_reg_bank_param.sv
// Bench for vme_reg_bank_param: directed vector table, hand sequences for
// streaming and reset-during-write, then random traffic against a register-array model.
module tb_vme_reg_bank_param;

  logic         Clk = 1'b0;
  logic         rst_n;
  logic [2:0]   VMEAddr;
  logic [31:0]  VMEWrData;
  logic         VMERdMem, VMEWrMem;
  logic [31:0]  VMERdData;
  logic         VMERdDone, VMEWrDone, VMERdErr, VMEWrErr;
  logic [127:0] ctrl_o;
  logic [3:0]   ctrl_wr_o;
  logic [63:0]  stat_set_i;

  always #5 Clk = ~Clk;

  vme_reg_bank_param #(
    .N_CTRL(4), .N_STAT(2), .REG_W(32), .ADDR_W(3), .PIPE_WR(1'b1),
    .CTRL_RST(128'hA5)
  ) dut (
    .Clk(Clk), .rst_n(rst_n), .VMEAddr(VMEAddr), .VMEWrData(VMEWrData),
    .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem), .VMERdData(VMERdData),
    .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone), .VMERdErr(VMERdErr),
    .VMEWrErr(VMEWrErr), .ctrl_o(ctrl_o), .ctrl_wr_o(ctrl_wr_o),
    .stat_set_i(stat_set_i)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain register arrays plus the one write waiting to commit
  logic [31:0] ctrl_m [4];
  logic [31:0] stat_m [2];
  bit          pend_wr;
  logic [2:0]  pend_a;
  logic [31:0] pend_d;
  bit          m_rdd, m_rde, m_wrd, m_wre;
  logic [31:0] m_rdata;
  logic [3:0]  m_cwr;

  typedef struct {
    bit          rd, wr;
    logic [2:0]  a;
    logic [31:0] wd;
    logic [63:0] set;
    bit          e_rdd, e_rde;
    logic [31:0] e_rdata;
    bit          e_wrd, e_wre;
    logic [3:0]  e_cwr;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    if (a < 3'd4) return ctrl_m[a[1:0]];
    if (a < 3'd6) return stat_m[a - 3'd4];
    return 32'h0;
  endfunction

  function automatic logic [127:0] m_ctrl_vec();
    return {ctrl_m[3], ctrl_m[2], ctrl_m[1], ctrl_m[0]};
  endfunction

  task automatic model_reset();
    ctrl_m[0] = 32'hA5; ctrl_m[1] = 32'h0; ctrl_m[2] = 32'h0; ctrl_m[3] = 32'h0;
    stat_m[0] = 32'h0;  stat_m[1] = 32'h0;
    pend_wr = 1'b0; pend_a = 3'd0; pend_d = 32'h0;
  endtask

  // Drive one cycle, advance the model across the clock edge, return #1 after it
  task automatic step(input bit rd, input bit wr, input logic [2:0] a,
                      input logic [31:0] wd, input logic [63:0] set);
    logic [31:0] clr0, clr1;
    VMERdMem = rd; VMEWrMem = wr; VMEAddr = a; VMEWrData = wd; stat_set_i = set;
    m_rdd   = rd;
    m_rde   = rd && (a >= 3'd6);
    m_rdata = rd ? m_read(a) : 32'h0;
    m_wrd   = pend_wr;
    m_wre   = pend_wr && (pend_a >= 3'd6);
    m_cwr   = 4'h0;
    clr0 = 32'h0; clr1 = 32'h0;
    if (pend_wr) begin
      if (pend_a < 3'd4) begin
        ctrl_m[pend_a[1:0]] = pend_d;
        m_cwr[pend_a[1:0]]  = 1'b1;
      end else if (pend_a == 3'd4) clr0 = pend_d;
      else if (pend_a == 3'd5)     clr1 = pend_d;
    end
    stat_m[0] = (stat_m[0] & ~clr0) | set[31:0];
    stat_m[1] = (stat_m[1] & ~clr1) | set[63:32];
    pend_wr = wr; pend_a = a; pend_d = wd;
    @(posedge Clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".rd_done"}, VMERdDone, m_rdd);
    chk({tag, ".rd_err"},  VMERdErr,  m_rde);
    chk({tag, ".rd_data"}, VMERdData, m_rdata);
    chk({tag, ".wr_done"}, VMEWrDone, m_wrd);
    chk({tag, ".wr_err"},  VMEWrErr,  m_wre);
    chk({tag, ".ctrl_wr"}, ctrl_wr_o, m_cwr);
    chk({tag, ".ctrl_o"},  ctrl_o,    m_ctrl_vec());
  endtask

  task automatic do_reset();
    VMERdMem = 1'b0; VMEWrMem = 1'b0; VMEAddr = 3'd0; VMEWrData = 32'h0; stat_set_i = 64'h0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int wr_cnt, rd_cnt;
    logic [63:0] rset;

    tbl[0]  = '{0,1,3'd1,32'hDEADBEEF,64'h0, 0,0,32'h0,        0,0,4'h0};
    tbl[1]  = '{0,0,3'd0,32'h0,       64'h0, 0,0,32'h0,        1,0,4'h2};
    tbl[2]  = '{1,0,3'd1,32'h0,       64'h0, 1,0,32'hDEADBEEF, 0,0,4'h0};
    tbl[3]  = '{1,0,3'd0,32'h0,       64'h0, 1,0,32'hA5,       0,0,4'h0};
    tbl[4]  = '{0,0,3'd0,32'h0,       64'h1, 0,0,32'h0,        0,0,4'h0};
    tbl[5]  = '{1,0,3'd4,32'h0,       64'h0, 1,0,32'h1,        0,0,4'h0};
    tbl[6]  = '{0,1,3'd4,32'h1,       64'h1, 0,0,32'h0,        0,0,4'h0};
    tbl[7]  = '{0,0,3'd0,32'h0,       64'h1, 0,0,32'h0,        1,0,4'h0};
    tbl[8]  = '{1,0,3'd4,32'h0,       64'h0, 1,0,32'h1,        0,0,4'h0};
    tbl[9]  = '{0,1,3'd4,32'h1,       64'h0, 0,0,32'h0,        0,0,4'h0};
    tbl[10] = '{0,0,3'd0,32'h0,       64'h0, 0,0,32'h0,        1,0,4'h0};
    tbl[11] = '{1,0,3'd4,32'h0,       64'h0, 1,0,32'h0,        0,0,4'h0};
    tbl[12] = '{1,0,3'd7,32'h0,       64'h0, 1,1,32'h0,        0,0,4'h0};
    tbl[13] = '{0,1,3'd7,32'hFFFFFFFF,64'h0, 0,0,32'h0,        0,0,4'h0};
    tbl[14] = '{0,0,3'd0,32'h0,       64'h0, 0,0,32'h0,        1,1,4'h0};
    tbl[15] = '{1,0,3'd1,32'h0,       64'h0, 1,0,32'hDEADBEEF, 0,0,4'h0};
    tbl[16] = '{1,1,3'd2,32'h12345678,64'h0, 1,0,32'h0,        0,0,4'h0};
    tbl[17] = '{1,0,3'd2,32'h0,       64'h0, 1,0,32'h0,        1,0,4'h4};
    tbl[18] = '{1,0,3'd2,32'h0,       64'h0, 1,0,32'h12345678, 0,0,4'h0};

    do_reset();
    chk("reset.ctrl_o",  ctrl_o, 128'hA5);
    chk("reset.rd_done", VMERdDone, 1'b0);
    chk("reset.wr_done", VMEWrDone, 1'b0);
    chk("reset.rd_err",  VMERdErr, 1'b0);
    chk("reset.wr_err",  VMEWrErr, 1'b0);
    chk("reset.ctrl_wr", ctrl_wr_o, 4'h0);
    chk("reset.rd_data", VMERdData, 32'h0);

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].set);
      chk($sformatf("vec%0d.rd_done", i), VMERdDone, tbl[i].e_rdd);
      chk($sformatf("vec%0d.rd_err", i),  VMERdErr,  tbl[i].e_rde);
      chk($sformatf("vec%0d.rd_data", i), VMERdData, tbl[i].e_rdata);
      chk($sformatf("vec%0d.wr_done", i), VMEWrDone, tbl[i].e_wrd);
      chk($sformatf("vec%0d.wr_err", i),  VMEWrErr,  tbl[i].e_wre);
      chk($sformatf("vec%0d.ctrl_wr", i), ctrl_wr_o, tbl[i].e_cwr);
      chk($sformatf("vec%0d.ctrl_o", i),  ctrl_o,    m_ctrl_vec());
    end

    // Back-to-back writes then back-to-back reads
    wr_cnt = 0; rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 4)      step(0, 1, 3'(i), 32'hC0DE0000 + 32'(i), 64'h0);
      else if (i < 8) step(1, 0, 3'(i - 4), 32'h0, 64'h0);
      else            step(0, 0, 3'd0, 32'h0, 64'h0);
      check_model($sformatf("stream%0d", i));
      wr_cnt += int'(VMEWrDone);
      rd_cnt += int'(VMERdDone);
    end
    chk("stream.wr_count", 128'(wr_cnt), 128'd4);
    chk("stream.rd_count", 128'(rd_cnt), 128'd4);

    // Reset asserted in the cycle after a write strobe drops that write
    step(0, 1, 3'd3, 32'h55555555, 64'h0);
    check_model("rstmid.strobe");
    VMEWrMem = 1'b0;
    rst_n    = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 3'd0, 32'h0, 64'h0);
      check_model($sformatf("rstmid%0d", i));
    end
    chk("rstmid.ctrl3", ctrl_o[127:96], 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rset = {$urandom & $urandom & $urandom, $urandom & $urandom & $urandom};
      if ($urandom_range(0, 3) != 0) rset = 64'h0;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           $urandom, rset);
      check_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
